// File: rtl/i2c_xfer_seq_if.sv
// i2c_xfer_seq_if: host request/result and byte-controller signals of i2c_xfer_seq.
// req_reg widens to 16 bits when I2C_SEQ_ADDR16_EN is defined.
interface i2c_xfer_seq_if;
`ifdef I2C_SEQ_ADDR16_EN
  localparam int RW = 16;
`else
  localparam int RW = 8;
`endif
  logic          req_valid;
  logic          req_ready;
  logic          req_rd;
  logic [6:0]    req_dev;
  logic [RW-1:0] req_reg;
  logic [7:0]    req_wdata;
  logic          xfer_done;
  logic [1:0]    xfer_err;
  logic [7:0]    rdata;
  logic          busy;
  logic          bc_start;
  logic          bc_stop;
  logic          bc_read;
  logic          bc_write;
  logic          bc_ack_in;
  logic [7:0]    bc_din;
  logic          bc_done;
  logic          bc_ack_out;
  logic          bc_al;
  logic [7:0]    bc_dout;
  modport slave (
    input  req_valid, req_rd, req_dev, req_reg, req_wdata, bc_done, bc_ack_out, bc_al, bc_dout,
    output req_ready, xfer_done, xfer_err, rdata, busy,
    output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );
  modport master (
    output req_valid, req_rd, req_dev, req_reg, req_wdata, bc_done, bc_ack_out, bc_al, bc_dout,
    input  req_ready, xfer_done, xfer_err, rdata, busy,
    input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );
endinterface

// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: sequences an I2C register read/write as byte-controller commands.
// Define I2C_SEQ_ADDR16_EN for 16-bit register addresses (REGH byte sent before REGL).
module i2c_xfer_seq #(
  parameter int TO_W = 20
) (
  input logic          clk,
  input logic          rstn,
  i2c_xfer_seq_if.slave bus
);
`ifdef I2C_SEQ_ADDR16_EN
  localparam int RW = 16;
  localparam bit A16 = 1'b1;
`else
  localparam int RW = 8;
  localparam bit A16 = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, DEVW, REGH, REGL, WDAT, DEVR, RDAT, ESTOP, FIN} state_t;
  state_t          state, state_n;
  logic [TO_W-1:0] cnt;
  logic [1:0]      err, err_n;
  logic [7:0]      rdata;
  logic            cmd_on, rd;
  logic [6:0]      dev;
  logic [RW-1:0]   reg_a;
  logic [7:0]      wdata;
  logic [4:0]      cmd;
  logic [7:0]      din;
  logic            accept, waiting, tmo, adv;
  assign accept  = state == IDLE && bus.req_valid;
  assign waiting = state inside {DEVW, REGH, REGL, WDAT, DEVR, RDAT, ESTOP};
  // the increment that would reach 2^TO_W-1 ends the wait
  assign tmo     = waiting && cnt == {{(TO_W-1){1'b1}}, 1'b0};
  assign adv     = waiting && bus.bc_done && !bus.bc_al && !tmo;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      cmd_on <= 1'b0;
      err    <= 2'b00;
      rdata  <= 8'h00;
      rd     <= 1'b0;
      dev    <= 7'h00;
      reg_a  <= '0;
      wdata  <= 8'h00;
    end else begin
      state  <= state_n;
      cnt    <= (state_n != state || !waiting) ? '0 : cnt + 1'b1;
      // commands of a newly entered state wait one cycle, except the first byte after accept
      cmd_on <= state == IDLE || state_n == state;
      err    <= err_n;
      if (accept) {rd, dev, reg_a, wdata} <= {bus.req_rd, bus.req_dev, bus.req_reg, bus.req_wdata};
      if (adv && state == RDAT) rdata <= bus.bc_dout;
    end
  end
  always_comb begin
    state_n = state;
    err_n   = err;
    if (accept) begin
      state_n = DEVW;
      err_n   = 2'b00;
    end else if (state == FIN) begin
      state_n = IDLE;
    end else if (waiting && bus.bc_al) begin
      state_n = FIN;
      err_n   = 2'b10;
    end else if (tmo) begin
      state_n = FIN;
      err_n   = 2'b11;
    end else if (adv && bus.bc_ack_out && state inside {DEVW, REGH, REGL, DEVR}) begin
      state_n = ESTOP;
      err_n   = 2'b01;
    end else if (adv) begin
      err_n = (state == WDAT && bus.bc_ack_out) ? 2'b01 : err;
      case (state)
        DEVW:    state_n = A16 ? REGH : REGL;
        REGH:    state_n = REGL;
        REGL:    state_n = rd ? DEVR : WDAT;
        DEVR:    state_n = RDAT;
        default: state_n = FIN;
      endcase
    end
  end
  always_comb begin
    cmd = 5'b00000;
    din = 8'h00;
    case (state)
      DEVW:    begin cmd = 5'b10010; din = {dev, 1'b0};     end
      REGH:    begin cmd = 5'b00010; din = reg_a[RW-1 -: 8]; end
      REGL:    begin cmd = 5'b00010; din = reg_a[7:0];       end
      WDAT:    begin cmd = 5'b01010; din = wdata;            end
      DEVR:    begin cmd = 5'b10010; din = {dev, 1'b1};     end
      RDAT:    cmd = 5'b01101;
      ESTOP:   cmd = 5'b01000;
      default: cmd = 5'b00000;
    endcase
  end
  assign {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in} = cmd_on ? cmd : 5'b00000;
  assign bus.bc_din    = cmd_on ? din : 8'h00;
  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.xfer_done = state == FIN;
  assign bus.xfer_err  = err;
  assign bus.rdata     = rdata;
endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb_i2c_xfer_seq: byte-level model of the expected command list per transaction,
// a byte-controller responder, and directed plus random transactions.
module tb_i2c_xfer_seq;
  localparam int TO_W = 4;
`ifdef I2C_SEQ_ADDR16_EN
  localparam int RW = 16;
`else
  localparam int RW = 8;
`endif
  localparam int ACK = 0, NACK = 1, AL = 2, HANG = 3;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  i2c_xfer_seq_if bus();
  i2c_xfer_seq #(.TO_W(TO_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int total = 0, bad = 0, cyc = 0, last_evt = 0, acc_cnt = 0, done_cnt = 0;
  int rb = 0, cur_o = 0, cur_l = 0, last_lat = 0;
  bit active = 0, rst_pend = 0;
  logic [12:0] cur;
  logic [12:0] cq[$];
  logic [12:0] logq[$];
  int oq[$], lq[$];
  int oc_s[6], lat_s[6];
  logic [7:0] dout_s = 8'h00, exp_rd = 8'h00, rd_h = 8'h00, last_rd = 8'h00;
  logic [1:0] exp_err = 2'b00, err_h = 2'b00, last_err = 2'b00;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // expected command list: {start,stop,read,write,ack_in,din} per byte, cut short by the first non-ACK
  task automatic build();
    logic [12:0] b[$];
    cq.delete(); oq.delete(); lq.delete();
    b.push_back({5'b10010, bus.req_dev, 1'b0});
`ifdef I2C_SEQ_ADDR16_EN
    b.push_back({5'b00010, bus.req_reg[15:8]});
`endif
    b.push_back({5'b00010, bus.req_reg[7:0]});
    if (bus.req_rd) begin
      b.push_back({5'b10010, bus.req_dev, 1'b1});
      b.push_back({5'b01101, 8'h00});
    end else b.push_back({5'b01010, bus.req_wdata});
    exp_err = 2'b00;
    exp_rd = rd_h;
    for (int i = 0; i < b.size(); i++) begin
      cq.push_back(b[i]); oq.push_back(oc_s[i]); lq.push_back(lat_s[i]);
      if (oc_s[i] == AL) begin exp_err = 2'b10; break; end
      if (oc_s[i] == HANG) begin exp_err = 2'b11; break; end
      if (oc_s[i] == NACK) begin
        exp_err = 2'b01;
        if (!b[i][11]) begin cq.push_back({5'b01000, 8'h00}); oq.push_back(ACK); lq.push_back(lat_s[5]); end
        break;
      end
      if (i == b.size() - 1 && bus.req_rd) exp_rd = dout_s;
    end
  endtask
  always @(negedge clk) begin
    logic [12:0] c;
    c = {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din};
    bus.bc_done = 1'b0; bus.bc_al = 1'b0; bus.bc_ack_out = 1'b0;
    if (!rstn) begin
      rst_pend = 1; active = 0; rb = 0; err_h = 2'b00; rd_h = 8'h00; bus.bc_dout = 8'h00;
      cq.delete(); oq.delete(); lq.delete();
    end else begin
      cyc++;
      if (rst_pend) begin
        chk("rst_cmd", c, 0); chk("rst_busy", bus.busy, 0); chk("rst_ready", bus.req_ready, 1);
        chk("rst_done", bus.xfer_done, 0); chk("rst_err", bus.xfer_err, 0); chk("rst_rdata", bus.rdata, 0);
        rst_pend = 0;
      end
      chk("busy", bus.busy, active);
      chk("ready", bus.req_ready, !active);
      if (!active) begin
        chk("idle_cmd", c, 0); chk("idle_done", bus.xfer_done, 0);
        chk("idle_err", bus.xfer_err, err_h); chk("idle_rdata", bus.rdata, rd_h);
        if (bus.req_valid) begin build(); active = 1; last_evt = cyc; logq.delete(); acc_cnt++; end
      end else begin
        if (rb == 2) begin chk("cmd_drop", c, 0); rb = 0; end
        else if (rb == 1) begin
          if (cur_o == HANG && c == 0) rb = 0; else chk("cmd_hold", c, cur);
        end else if (c != 0) begin
          logq.push_back(c);
          if (cq.size() == 0) chk("cmd_extra", c, 0);
          else begin
            chk("cmd", c, cq[0]);
            cur = c; void'(cq.pop_front()); cur_o = oq.pop_front(); cur_l = lq.pop_front(); rb = 1;
          end
        end
        if (rb == 1 && cur_o != HANG) begin
          if (cur_l == 0) begin
            bus.bc_al = cur_o == AL;
            bus.bc_done = cur_o != AL || $urandom_range(1) == 1;
            bus.bc_ack_out = cur_o == NACK;
            bus.bc_dout = cur[10] ? dout_s : 8'($urandom);
            last_evt = cyc; rb = 2;
          end else cur_l--;
        end
        if (bus.xfer_done) begin
          last_err = bus.xfer_err; last_rd = bus.rdata; last_lat = cyc - last_evt;
          chk("done_err", bus.xfer_err, exp_err); chk("done_rdata", bus.rdata, exp_rd);
          chk("done_lat", last_lat, exp_err == 2'b11 ? 1 << TO_W : 1);
          chk("done_left", cq.size(), 0);
          err_h = exp_err; rd_h = exp_rd; active = 0; rb = 0; done_cnt++;
        end
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bail(string nm);
    total++; bad++;
    $display("FAIL %s: no progress within cycle budget", nm);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask
  task automatic script(int o0, int o1, int o2, int o3);
    oc_s = '{o0, o1, o2, o3, ACK, ACK};
    lat_s = '{1, 1, 1, 1, 1, 1};
  endtask
  task automatic run(bit rd, logic [6:0] dev, logic [RW-1:0] ra, logic [7:0] wd);
    int a0, k;
    a0 = acc_cnt; k = 0;
    bus.req_rd = rd; bus.req_dev = dev; bus.req_reg = ra; bus.req_wdata = wd; bus.req_valid = 1'b1;
    do begin tick(1); k++; end while (acc_cnt == a0 && k < 50);
    if (acc_cnt == a0) bail("accept_wait");
    // junk request while busy must be ignored
    bus.req_rd = ~rd; bus.req_dev = 7'($urandom); bus.req_reg = RW'($urandom); bus.req_wdata = 8'($urandom);
    tick(2);
    bus.req_valid = 1'b0;
    k = 0;
    while (active && k < 400) begin tick(1); k++; end
    if (active) bail("done_wait");
  endtask
  initial begin
    int d0, k;
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_dev = '0; bus.req_reg = '0; bus.req_wdata = '0;
    tick(3);
    rstn = 1'b1;
    tick(2);
`ifndef I2C_SEQ_ADDR16_EN
    script(ACK, ACK, ACK, ACK);
    run(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("wr_n", logq.size(), 3); chk("wr_b0", logq[0], 13'h12A0);
    chk("wr_b1", logq[1], 13'h0210); chk("wr_b2", logq[2], 13'h0AA5); chk("wr_err", last_err, 2'b00);
    script(ACK, ACK, ACK, ACK); dout_s = 8'h3C;
    run(1'b1, 7'h50, 8'h10, 8'h00);
    chk("rd_n", logq.size(), 4); chk("rd_b2", logq[2], 13'h12A1); chk("rd_b3", logq[3], 13'h0D00);
    chk("rd_data", last_rd, 8'h3C); chk("rd_err", last_err, 2'b00);
    script(NACK, ACK, ACK, ACK);
    run(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("nack_n", logq.size(), 2); chk("nack_stop", logq[1], 13'h0800); chk("nack_err", last_err, 2'b01);
    script(ACK, AL, ACK, ACK);
    run(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("al_n", logq.size(), 2); chk("al_b1", logq[1], 13'h0210); chk("al_err", last_err, 2'b10);
    script(HANG, ACK, ACK, ACK);
    run(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("to_n", logq.size(), 1); chk("to_lat", last_lat, 16); chk("to_err", last_err, 2'b11);
`else
    script(ACK, ACK, ACK, ACK);
    run(1'b0, 7'h50, 16'h1234, 8'h5A);
    chk("a16_n", logq.size(), 4); chk("a16_b0", logq[0], 13'h12A0); chk("a16_b1", logq[1], 13'h0212);
    chk("a16_b2", logq[2], 13'h0234); chk("a16_b3", logq[3], 13'h0A5A); chk("a16_err", last_err, 2'b00);
`endif
    // reset in the middle of a slow transaction: no completion may follow
    oc_s = '{ACK, ACK, ACK, ACK, ACK, ACK}; lat_s = '{4, 4, 4, 4, 4, 4}; dout_s = 8'h77;
    d0 = done_cnt; k = acc_cnt;
    bus.req_rd = 1'b1; bus.req_dev = 7'h2B; bus.req_reg = '0; bus.req_wdata = 8'h00; bus.req_valid = 1'b1;
    tick(1);
    bus.req_valid = 1'b0;
    chk("mid_acc", acc_cnt, k + 1);
    tick(8);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(20);
    chk("mid_nodone", done_cnt, d0);
    for (int t = 0; t < 150; t++) begin
      bit rd;
      int nb;
      rd = $urandom_range(1) == 1;
      nb = (RW == 16 ? 4 : 3) + int'(rd);
      for (int i = 0; i < 6; i++) begin
        int r;
        r = $urandom_range(99);
        oc_s[i] = r < 78 ? ACK : r < 88 ? NACK : r < 95 ? AL : HANG;
        lat_s[i] = $urandom_range(4);
      end
      if (rd && oc_s[nb-1] == NACK) oc_s[nb-1] = ACK;
      dout_s = 8'($urandom);
      run(rd, 7'($urandom), RW'($urandom), 8'($urandom));
    end
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
